// File: rtl/tile_pkg.sv
// tile_pkg: shared definitions for the piano-tiles sequencer.
//   - run-state encoding (state_t)
//   - default geometry and tick-divider timing
//   - widths of the step, score and miss counters
package tile_pkg;

   localparam int LANES_DEF     = 4;
   localparam int SONG_LEN_DEF  = 72;
   localparam int START_DIV_DEF = 12500000;
   localparam int MIN_DIV_DEF   = 3125000;
   localparam int DIV_STEP_DEF  = 1250000;

   localparam int STEP_W  = 7;
   localparam int SCORE_W = 8;
   localparam int MISS_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4,
      S_OVER  = 3'd5
   } state_t;

endpackage

// File: rtl/tile_tick_div.sv
// tile_tick_div: row-period divider.
// Ports:
//   clk, reset (async, active-low)
//   en      - count this cycle (low = hold)
//   clr     - synchronous clear of the count, wins over en
//   cur_div - cycles per row, may change at run time
//   tick    - high for one cycle when the count reaches cur_div-1
module tile_tick_div #(
   parameter int DIV_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] cur_div,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt;

   assign tick = en && !clr && (div_cnt == cur_div - DIV_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/tile_scroll_ctrl.sv
// tile_scroll_ctrl: game sequencer for the piano-tiles note datapath.
// Owns the scroll tick, drives the lane shift register (load / shift_en),
// judges lane keys against the outgoing row and keeps score and misses.
// Ports:
//   CLOCK_50, reset (async, active-low)
//   start, pause     - level inputs, rising edges detected here
//   keys[LANES]      - lane buttons, rising edges detected here
//   row[LANES]       - row currently leaving the shift register
//   load, shift_en   - one-cycle strobes to the shift register
//   step_idx, score, misses, state, done, win - game status
// Build option: define TILE_SPEEDUP_EN to shorten the row period by
// DIV_STEP (floored at MIN_DIV) every SPEEDUP_ROWS rows; otherwise the
// period stays at START_DIV.
module tile_scroll_ctrl
   import tile_pkg::*;
#(
   parameter int LANES          = LANES_DEF,
   parameter int SONG_LEN       = SONG_LEN_DEF,
   parameter int DIV_W          = 26,
   parameter int START_DIV      = START_DIV_DEF,
   parameter int MIN_DIV        = MIN_DIV_DEF,
   parameter int DIV_STEP       = DIV_STEP_DEF,
   parameter int SPEEDUP_ROWS   = 16,
   parameter int COUNTDOWN_ROWS = 3,
   parameter int MAX_MISSES     = 8
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic [LANES-1:0]   keys,
   input  logic [LANES-1:0]   row,
   output logic               load,
   output logic               shift_en,
   output logic [STEP_W-1:0]  step_idx,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  misses,
   output logic [2:0]         state,
   output logic               done,
   output logic               win
);

   localparam int CD_W = (COUNTDOWN_ROWS < 2) ? 1 : $clog2(COUNTDOWN_ROWS);

   if (MIN_DIV < 1 || DIV_STEP < 0 || SPEEDUP_ROWS < 1 || START_DIV < MIN_DIV) begin : g_bad_cfg
      $error("tile_scroll_ctrl: inconsistent divider configuration");
   end

   function automatic logic [7:0] popcnt(input logic [LANES-1:0] v);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) c = c + 8'(v[i]);
      return c;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                    input logic [7:0] inc);
      logic [8:0] sum;
      sum = 9'(s) + 9'(inc);
      return (sum > 9'((1 << SCORE_W) - 1)) ? '1 : SCORE_W'(sum);
   endfunction

   function automatic logic [MISS_W-1:0] sat_miss(input logic [MISS_W-1:0] m,
                                                  input logic [7:0] inc);
      logic [8:0] sum;
      sum = 9'(m) + 9'(inc);
      return (sum > 9'((1 << MISS_W) - 1)) ? '1 : MISS_W'(sum);
   endfunction

   state_t           st, st_nxt;
   logic             start_q, pause_q;
   logic [LANES-1:0] keys_q, hit;
   logic             start_e, pause_e;
   logic [LANES-1:0] key_e;
   logic [CD_W-1:0]  cd_cnt;
   logic [DIV_W-1:0] cur_div;
   logic             tick, playing, play_tick, last_row, cd_last, over_hit;
   logic [LANES-1:0] judge_hit, judge_bad, flags_upd, tick_miss;
   logic             load_d, shift_d;

   assign start_e = start & ~start_q;
   assign pause_e = pause & ~pause_q;
   assign key_e   = keys & ~keys_q;

   tile_tick_div #(.DIV_W(DIV_W)) u_div (
      .clk     (CLOCK_50),
      .reset   (reset),
      .en      ((st == S_COUNT) || (st == S_PLAY)),
      .clr     (start_e),
      .cur_div (cur_div),
      .tick    (tick)
   );

   // Keys are judged against the outgoing row first; the tick's miss check
   // then sees the flags including any hit landed in the same cycle.
   assign playing   = (st == S_PLAY) && !start_e;
   assign play_tick = playing && tick;
   assign judge_hit = playing ? (key_e & row & ~hit) : '0;
   assign judge_bad = playing ? (key_e & ~(row & ~hit)) : '0;
   assign flags_upd = hit | judge_hit;
   assign tick_miss = play_tick ? (row & ~flags_upd) : '0;
   assign last_row  = (step_idx == STEP_W'(SONG_LEN - 1));
   assign cd_last   = (cd_cnt == CD_W'(COUNTDOWN_ROWS - 1));
   assign over_hit  = (int'(misses) >= MAX_MISSES);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) st <= S_IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_IDLE, S_DONE, S_OVER: if (start_e) st_nxt = S_COUNT;
         S_COUNT: begin
            if (start_e)              st_nxt = S_COUNT;
            else if (tick && cd_last) st_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (start_e)                st_nxt = S_COUNT;
            else if (over_hit)          st_nxt = S_OVER;
            else if (tick && last_row)  st_nxt = S_DONE;
            else if (pause_e)           st_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (start_e)      st_nxt = S_COUNT;
            else if (pause_e) st_nxt = S_PLAY;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      done    = (st == S_DONE) || (st == S_OVER);
      win     = (st == S_DONE);
      load_d  = start_e;
      shift_d = play_tick;
   end

   assign state = st;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         start_q  <= 1'b0;
         pause_q  <= 1'b0;
         keys_q   <= '0;
         load     <= 1'b0;
         shift_en <= 1'b0;
         step_idx <= '0;
         score    <= '0;
         misses   <= '0;
         hit      <= '0;
         cd_cnt   <= '0;
      end else begin
         start_q  <= start;
         pause_q  <= pause;
         keys_q   <= keys;
         load     <= load_d;
         shift_en <= shift_d;
         if (start_e) begin
            step_idx <= '0;
            score    <= '0;
            misses   <= '0;
            hit      <= '0;
            cd_cnt   <= '0;
         end else begin
            if (st == S_COUNT && tick) cd_cnt <= cd_last ? '0 : cd_cnt + CD_W'(1);
            if (playing) begin
               score  <= sat_score(score, popcnt(judge_hit));
               misses <= sat_miss(misses, popcnt(judge_bad) + popcnt(tick_miss));
               hit    <= play_tick ? '0 : flags_upd;
               if (play_tick) step_idx <= step_idx + STEP_W'(1);
            end
         end
      end
   end

`ifdef TILE_SPEEDUP_EN
   logic speed_wrap;
   assign speed_wrap = (((int'(step_idx) + 1) % SPEEDUP_ROWS) == 0);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         cur_div <= DIV_W'(START_DIV);
      end else if (start_e) begin
         cur_div <= DIV_W'(START_DIV);
      end else if (play_tick && speed_wrap) begin
         cur_div <= (cur_div >= DIV_W'(MIN_DIV + DIV_STEP)) ? cur_div - DIV_W'(DIV_STEP)
                                                            : DIV_W'(MIN_DIV);
      end
   end
`else
   assign cur_div = DIV_W'(START_DIV);
`endif

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// tb_tile_scroll_ctrl: directed bench for tile_scroll_ctrl with a short
// song (START_DIV=8, MIN_DIV=4, DIV_STEP=2, SONG_LEN=20, 3-row countdown).
module tb_tile_scroll_ctrl;

   logic       clk;
   logic       reset;
   logic       start, pause;
   logic [3:0] keys, row;
   logic       load, shift_en, done, win;
   logic [6:0] step_idx;
   logic [7:0] score;
   logic [3:0] misses;
   logic [2:0] state;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef TILE_SPEEDUP_EN
   localparam int FAST_PER = 6;
`else
   localparam int FAST_PER = 8;
`endif

   tile_scroll_ctrl #(
      .LANES(4), .SONG_LEN(20), .DIV_W(8), .START_DIV(8), .MIN_DIV(4),
      .DIV_STEP(2), .SPEEDUP_ROWS(16), .COUNTDOWN_ROWS(3), .MAX_MISSES(8)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .keys     (keys),
      .row      (row),
      .load     (load),
      .shift_en (shift_en),
      .step_idx (step_idx),
      .score    (score),
      .misses   (misses),
      .state    (state),
      .done     (done),
      .win      (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // Clocks until shift_en is seen; n is the number of edges taken.
   task automatic wait_shift(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!shift_en && n < 200);
      if (!shift_en) chk_val("shift_timeout", int'(shift_en), 1);
   endtask

   int  n;
   logic saw_shift;

   initial begin
      reset = 1'b0; start = 1'b0; pause = 1'b0; keys = '0; row = '0;
      repeat (3) cyc();
      chk_val("rst_state", state, 0);
      chk_val("rst_load", load, 0);
      chk_val("rst_shift", shift_en, 0);
      chk_val("rst_done", done, 0);
      reset = 1'b1;
      cyc();

      // Pause edge in IDLE is ignored.
      pause = 1'b1; cyc(); pause = 1'b0; cyc();
      chk_val("idle_pause_ignored", state, 0);

      // Run 1: start timing, judging.
      press_start();
      chk_val("start_load", load, 1);
      chk_val("start_state", state, 1);
      cyc();
      chk_val("load_one_cycle", load, 0);
      n = 1;
      while (!shift_en && n < 200) begin cyc(); n++; end
      chk_val("first_shift_lat", n, 32);
      chk_val("play_state", state, 2);
      chk_val("step_1", step_idx, 1);
      wait_shift(n);
      chk_val("period_2", n, 8);

      // Two hits on row 1010 before the tick.
      row = 4'b1010;
      keys = 4'b1000; cyc();
      chk_val("hit_lane3", score, 1);
      keys = 4'b0000; cyc();
      keys = 4'b0010; cyc();
      keys = 4'b0000;
      chk_val("hit_lane1", score, 2);
      wait_shift(n);
      chk_val("period_after_hits", n, 5);
      chk_val("hits_no_miss", misses, 0);

      // Unplayed row 1010: two misses at the tick.
      wait_shift(n);
      chk_val("tick_misses", misses, 2);
      chk_val("tick_score_hold", score, 2);

      // Wrong lane, then a hit landing on the tick cycle.
      keys = 4'b0100; cyc();
      chk_val("wrong_lane_miss", misses, 3);
      keys = 4'b0000;
      repeat (6) cyc();
      keys = 4'b1000; row = 4'b1000; cyc();
      keys = 4'b0000; row = 4'b0000;
      chk_val("tick_key_shift", shift_en, 1);
      chk_val("tick_key_score", score, 3);
      chk_val("tick_key_nomiss", misses, 3);
      chk_val("step_5", step_idx, 5);

      // Asynchronous reset in the middle of a cycle.
      #2 reset = 1'b0;
      #1;
      chk_val("async_state", state, 0);
      chk_val("async_score", score, 0);
      chk_val("async_misses", misses, 0);
      chk_val("async_shift", shift_en, 0);
      chk_val("async_step", step_idx, 0);
      cyc();
      reset = 1'b1;
      cyc();

      // Run 2: pause at step 3 for 100 cycles.
      press_start();
      wait_shift(n);
      wait_shift(n);
      wait_shift(n);
      chk_val("pre_pause_step", step_idx, 3);
      repeat (3) cyc();
      pause = 1'b1; cyc(); pause = 1'b0;
      chk_val("paused", state, 3);
      saw_shift = 1'b0;
      row = 4'b1111;
      for (int i = 0; i < 100; i++) begin
         keys = i[0] ? 4'b1111 : 4'b0000;
         cyc();
         if (shift_en) saw_shift = 1'b1;
      end
      keys = 4'b0000; cyc();
      chk_val("pause_no_shift", int'(saw_shift), 0);
      chk_val("pause_state_hold", state, 3);
      chk_val("pause_step_hold", step_idx, 3);
      chk_val("pause_keys_ignored", score, 0);
      chk_val("pause_miss_hold", misses, 0);
      pause = 1'b1; row = 4'b0000; cyc(); pause = 1'b0;
      chk_val("resumed", state, 2);
      wait_shift(n);
      chk_val("resume_offset", n, 4);
      chk_val("resume_step", step_idx, 4);

      // Clean run to the end; period shortens after 16 rows when enabled.
      for (int k = 5; k <= 20; k++) begin
         wait_shift(n);
         chk_val($sformatf("period_step%0d", k), n, (k > 16) ? FAST_PER : 8);
      end
      chk_val("done_state", state, 4);
      chk_val("done_flag", done, 1);
      chk_val("done_win", win, 1);
      repeat (20) cyc();
      chk_val("done_step_hold", step_idx, 20);
      chk_val("done_shift_quiet", shift_en, 0);

      // Run 3: restart from DONE, miss 8 notes -> OVER.
      press_start();
      chk_val("restart_load", load, 1);
      chk_val("restart_state", state, 1);
      chk_val("restart_step", step_idx, 0);
      wait_shift(n);
      chk_val("restart_latency", n, 32);
      row = 4'b1111;
      wait_shift(n);
      chk_val("over_miss4", misses, 4);
      wait_shift(n);
      chk_val("over_miss8", misses, 8);
      cyc();
      row = 4'b0000;
      chk_val("over_state", state, 5);
      chk_val("over_done", done, 1);
      chk_val("over_win", win, 0);
      repeat (10) cyc();
      chk_val("over_miss_hold", misses, 8);
      chk_val("over_step_hold", step_idx, 3);

      // Restart from OVER, then again mid-COUNT.
      press_start();
      chk_val("over_restart", state, 1);
      chk_val("over_restart_miss", misses, 0);
      repeat (10) cyc();
      press_start();
      chk_val("count_restart_load", load, 1);
      wait_shift(n);
      chk_val("count_restart_lat", n, 32);
      chk_val("count_restart_state", state, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
